// File: rtl/fft_vis_pkg.sv
// Shared types and constants for the FFT bar scanner.
// Holds the scan FSM states, the magnitude shift constants and the start-retry timeout.
package fft_vis_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StKick,
    StWaitLow,
    StWaitHigh,
    StScan,
    StDrain
  } scan_state_e;

  // mag ~= max + (min >> 2) + (min >> 3)
  localparam int unsigned AlphaShift = 2;
  localparam int unsigned BetaShift  = 3;

  // Cycles fft_done may stay high after a kick before the start is considered lost.
  localparam int unsigned WaitLowTimeout = 4;

endpackage

// File: rtl/mag_approx.sv
// Two-stage alpha-max-beta-min magnitude approximation of a signed complex sample.
// Stage 1 registers saturating absolute values; stage 2 registers the combined magnitude.
module mag_approx
  import fft_vis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 18
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] data_r,
  input  logic signed [DATA_WIDTH-1:0] data_i,
  output logic        [DATA_WIDTH:0]   mag
);

  localparam int unsigned AbsW = DATA_WIDTH - 1;
  localparam int unsigned MagW = DATA_WIDTH + 1;

  logic [AbsW-1:0] abs_r_d, abs_i_d, abs_r_q, abs_i_q;
  logic [AbsW-1:0] mx, mn;
  logic [MagW-1:0] mag_d, mag_q;

  // The most negative input has no positive twin, so it clamps to the largest magnitude.
  function automatic logic [AbsW-1:0] abs_sat(input logic [DATA_WIDTH-1:0] x);
    logic [DATA_WIDTH-1:0] neg;
    if (!x[DATA_WIDTH-1]) begin
      return x[AbsW-1:0];
    end
    if (x[AbsW-1:0] == '0) begin
      return '1;
    end
    neg = ~x + 1'b1;
    return neg[AbsW-1:0];
  endfunction

  always_comb begin
    abs_r_d = abs_sat(data_r);
    abs_i_d = abs_sat(data_i);
  end

  always_comb begin
    mx    = (abs_r_q >= abs_i_q) ? abs_r_q : abs_i_q;
    mn    = (abs_r_q >= abs_i_q) ? abs_i_q : abs_r_q;
    mag_d = MagW'(mx) + MagW'(mn >> AlphaShift) + MagW'(mn >> BetaShift);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      abs_r_q <= '0;
      abs_i_q <= '0;
      mag_q   <= '0;
    end else begin
      abs_r_q <= abs_r_d;
      abs_i_q <= abs_i_d;
      mag_q   <= mag_d;
    end
  end

  assign mag = mag_q;

endmodule

// File: rtl/fft_bar_scanner.sv
// Sweeps the FFT output bins after each transform, turning magnitudes into peak-hold bars
// with per-frame decay, and re-kicks the FFT so it runs back to back.
module fft_bar_scanner
  import fft_vis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 18,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned BAR_BITS   = 8,
  parameter int unsigned MAG_SHIFT  = 10,
  parameter int unsigned DECAY      = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fft_done,
  output logic                         fft_start,
  output logic        [ADDR_WIDTH-2:0] vga_addr,
  input  logic signed [DATA_WIDTH-1:0] vga_data_r,
  input  logic signed [DATA_WIDTH-1:0] vga_data_i,
  input  logic                         frame_tick,
  input  logic        [ADDR_WIDTH-2:0] bar_rd_addr,
  output logic        [BAR_BITS-1:0]   bar_rd_data,
  output logic                         busy
);

  localparam int unsigned IdxW    = ADDR_WIDTH - 1;
  localparam int unsigned NumBins = 2 ** IdxW;
  localparam int unsigned MagW    = DATA_WIDTH + 1;
  localparam int unsigned HMax    = 2 ** BAR_BITS - 1;
  localparam int unsigned CntW    = $clog2(WaitLowTimeout);

  scan_state_e       state_q, state_d;
  logic [CntW-1:0]   wcnt_q, wcnt_d;
  logic [IdxW-1:0]   addr_d;
  logic              issue;

  // Valid/index pipeline tracking each bin from address issue to bar write.
  logic              v1_q, v2_q, v3_q;
  logic [IdxW-1:0]   idx1_q, idx2_q, idx3_q;

  logic [MagW-1:0]     mag;
  logic [MagW-1:0]     mag_sh;
  logic [BAR_BITS-1:0] h;

  logic [BAR_BITS-1:0] bar_q [NumBins];
  logic [BAR_BITS-1:0] bar_d [NumBins];
  logic [BAR_BITS-1:0] base  [NumBins];

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    addr_d  = vga_addr;
    issue   = 1'b0;
    unique case (state_q)
      StIdle: state_d = StKick;
      StKick: begin
        wcnt_d  = '0;
        state_d = StWaitLow;
      end
      StWaitLow: begin
        if (!fft_done) begin
          state_d = StWaitHigh;
        end else if (wcnt_q == CntW'(WaitLowTimeout - 1)) begin
          state_d = StKick;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      StWaitHigh: begin
        if (fft_done) begin
          state_d = StScan;
          addr_d  = '0;
        end
      end
      StScan: begin
        issue = 1'b1;
        if (vga_addr == IdxW'(NumBins - 1)) begin
          state_d = StDrain;
        end else begin
          addr_d = vga_addr + 1'b1;
        end
      end
      StDrain: begin
        if (!(v1_q || v2_q || v3_q)) begin
          state_d = StKick;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign fft_start = (state_q == StKick);
  assign busy      = (state_q != StIdle);

  mag_approx #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mag_approx (
    .clk    (clk),
    .rst    (rst),
    .data_r (vga_data_r),
    .data_i (vga_data_i),
    .mag    (mag)
  );

  always_comb begin
    mag_sh = mag >> MAG_SHIFT;
    h      = (mag_sh > MagW'(HMax)) ? BAR_BITS'(HMax) : mag_sh[BAR_BITS-1:0];
  end

  // Decay is applied before the peak compare, so a tick on a write edge still keeps the peak.
  always_comb begin
    for (int i = 0; i < NumBins; i++) begin
      base[i]  = bar_q[i];
      bar_d[i] = bar_q[i];
      if (frame_tick) begin
        base[i] = (bar_q[i] >= BAR_BITS'(DECAY)) ? bar_q[i] - BAR_BITS'(DECAY) : '0;
      end
      bar_d[i] = base[i];
      if (v3_q && (idx3_q == IdxW'(i)) && (h > base[i])) begin
        bar_d[i] = h;
      end
    end
  end

  assign bar_rd_data = bar_q[bar_rd_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      wcnt_q   <= '0;
      vga_addr <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      idx1_q   <= '0;
      idx2_q   <= '0;
      idx3_q   <= '0;
      for (int i = 0; i < NumBins; i++) begin
        bar_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      vga_addr <= addr_d;
      v1_q     <= issue;
      idx1_q   <= vga_addr;
      v2_q     <= v1_q;
      idx2_q   <= idx1_q;
      v3_q     <= v2_q;
      idx3_q   <= idx2_q;
      for (int i = 0; i < NumBins; i++) begin
        bar_q[i] <= bar_d[i];
      end
    end
  end

endmodule

// File: tb/tb_fft_bar_scanner.sv
// Directed bench for fft_bar_scanner: two instances (MAG_SHIFT 10 and 8) share one bin memory
// and control inputs; expected bar heights go through a scoreboard queue.
module tb_fft_bar_scanner;

  logic               clk;
  logic               rst;
  logic               fft_done;
  logic               frame_tick;
  logic [3:0]         bar_rd_addr;

  logic               fft_start_a, busy_a, fft_start_b, busy_b;
  logic [3:0]         vga_addr_a, vga_addr_b;
  logic signed [17:0] data_r_a, data_i_a, data_r_b, data_i_b;
  logic [7:0]         bar_a, bar_b;

  logic signed [17:0] mem_r [16];
  logic signed [17:0] mem_i [16];

  typedef struct {
    bit inst_b;
    int idx;
    int val;
  } exp_t;

  exp_t sb [$];
  int   exp_a [16];
  int   exp_b [16];
  int   checks = 0;
  int   errors = 0;

  fft_bar_scanner #(
    .DATA_WIDTH (18),
    .ADDR_WIDTH (5),
    .BAR_BITS   (8),
    .MAG_SHIFT  (10),
    .DECAY      (1)
  ) dut_a (
    .clk         (clk),
    .rst         (rst),
    .fft_done    (fft_done),
    .fft_start   (fft_start_a),
    .vga_addr    (vga_addr_a),
    .vga_data_r  (data_r_a),
    .vga_data_i  (data_i_a),
    .frame_tick  (frame_tick),
    .bar_rd_addr (bar_rd_addr),
    .bar_rd_data (bar_a),
    .busy        (busy_a)
  );

  fft_bar_scanner #(
    .DATA_WIDTH (18),
    .ADDR_WIDTH (5),
    .BAR_BITS   (8),
    .MAG_SHIFT  (8),
    .DECAY      (1)
  ) dut_b (
    .clk         (clk),
    .rst         (rst),
    .fft_done    (fft_done),
    .fft_start   (fft_start_b),
    .vga_addr    (vga_addr_b),
    .vga_data_r  (data_r_b),
    .vga_data_i  (data_i_b),
    .frame_tick  (frame_tick),
    .bar_rd_addr (bar_rd_addr),
    .bar_rd_data (bar_b),
    .busy        (busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read FFT memory: data follows the address by one edge.
  always @(posedge clk) begin
    data_r_a <= mem_r[vga_addr_a];
    data_i_a <= mem_i[vga_addr_a];
    data_r_b <= mem_r[vga_addr_b];
    data_i_b <= mem_i[vga_addr_b];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push_all();
    for (int i = 0; i < 16; i++) begin
      sb.push_back('{inst_b: 1'b0, idx: i, val: exp_a[i]});
      sb.push_back('{inst_b: 1'b1, idx: i, val: exp_b[i]});
    end
  endtask

  task automatic check_bars(input string phase);
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bar_rd_addr = 4'(e.idx);
      #1;
      chk($sformatf("%s_bar%s%0d", phase, e.inst_b ? "B" : "A", e.idx),
          e.inst_b ? 32'(bar_b) : 32'(bar_a), 32'(e.val));
    end
    @(negedge clk);
  endtask

  task automatic decay_model();
    for (int i = 0; i < 16; i++) begin
      exp_a[i] = (exp_a[i] > 0) ? exp_a[i] - 1 : 0;
      exp_b[i] = (exp_b[i] > 0) ? exp_b[i] - 1 : 0;
    end
  endtask

  task automatic peak_model(input int idx, input int ha, input int hb);
    if (ha > exp_a[idx]) exp_a[idx] = ha;
    if (hb > exp_b[idx]) exp_b[idx] = hb;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) begin
      mem_r[i] = '0;
      mem_i[i] = '0;
    end
  endtask

  // Returns at a negedge where fft_start is high, or flags a failure after a bounded wait.
  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (fft_start_a) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
    chk("start_timeout", 32'd0, 32'd1);
  endtask

  // From a kick, emulate one transform and let the scan run to completion.
  task automatic scan_frame(input int tick_at, input bit timing);
    bit ok;
    wait_start(ok);
    fft_done = 1'b0;
    repeat (2) @(negedge clk);
    fft_done = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      frame_tick = (n == tick_at);
      if (timing && n == 4) chk("scan_addr3", 32'(vga_addr_a), 32'd3);
      if (timing && n == 7) begin
        bar_rd_addr = 4'd3;
        #1 chk("bar3_before_e4", 32'(bar_a), 32'd0);
      end
      if (timing && n == 8) begin
        #1 chk("bar3_at_e4", 32'(bar_a), 32'd5);
      end
    end
    frame_tick = 1'b0;
  endtask

  initial begin
    bit ok;
    int gap;
    rst         = 1'b1;
    fft_done    = 1'b1;
    frame_tick  = 1'b0;
    bar_rd_addr = '0;
    clear_mem();
    for (int i = 0; i < 16; i++) begin
      exp_a[i] = 0;
      exp_b[i] = 0;
    end

    // Reset state and first kick.
    repeat (2) @(negedge clk);
    chk("rst_start", 32'(fft_start_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_addr", 32'(vga_addr_a), 32'd0);
    chk("rst_bar0", 32'(bar_a), 32'd0);
    rst = 1'b0;
    #1 chk("idle_busy", 32'(busy_a), 32'd0);
    @(negedge clk);
    chk("kick_start", 32'(fft_start_a), 32'd1);
    chk("kick_busy", 32'(busy_a), 32'd1);

    // fft_done held high: the lost start is retried after the timeout.
    gap = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (fft_start_a) begin
        gap = n;
        break;
      end
    end
    chk("rekick_gap", 32'(gap), 32'd5);
    chk("rekick_busy", 32'(busy_a), 32'd1);

    // Bin magnitudes including saturating abs and bar saturation.
    mem_r[0] = -18'sd131072;
    mem_r[1] = -18'sd131072;
    mem_i[1] = -18'sd131072;
    mem_r[3] = 18'sd3000;
    mem_i[3] = -18'sd4000;
    peak_model(0, 127, 255);
    peak_model(1, 175, 255);
    peak_model(3, 5, 20);
    push_all();
    scan_frame(-1, 1'b1);
    check_bars("mag");

    // Asynchronous reset in the middle of a scan.
    wait_start(ok);
    fft_done = 1'b0;
    repeat (2) @(negedge clk);
    fft_done = 1'b1;
    repeat (8) @(negedge clk);
    chk("pre_rst_addr", 32'(vga_addr_a), 32'd7);
    bar_rd_addr = 4'd1;
    #2 rst = 1'b1;
    #1;
    chk("arst_start", 32'(fft_start_a), 32'd0);
    chk("arst_busy", 32'(busy_a), 32'd0);
    chk("arst_addr", 32'(vga_addr_a), 32'd0);
    chk("arst_barA1", 32'(bar_a), 32'd0);
    chk("arst_barB1", 32'(bar_b), 32'd0);
    for (int i = 0; i < 16; i++) begin
      exp_a[i] = 0;
      exp_b[i] = 0;
    end
    @(negedge clk);
    rst = 1'b0;
    #1 chk("arst_idle", 32'(busy_a), 32'd0);
    @(negedge clk);
    chk("arst_rekick", 32'(fft_start_a), 32'd1);

    // Peak capture on bin 2.
    clear_mem();
    mem_r[2] = 18'sd10240;
    peak_model(2, 10, 40);
    push_all();
    scan_frame(-1, 1'b0);
    check_bars("peak");

    // Three frame ticks with no new data.
    for (int t = 0; t < 3; t++) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      decay_model();
    end
    push_all();
    check_bars("decay");

    // A smaller magnitude leaves the held bar alone.
    mem_r[2] = 18'sd4096;
    peak_model(2, 4, 16);
    push_all();
    scan_frame(-1, 1'b0);
    check_bars("hold");

    // A frame tick on the same edge as the bin-2 write decays first, then compares.
    mem_r[2] = 18'sd9216;
    decay_model();
    peak_model(2, 9, 36);
    push_all();
    scan_frame(6, 1'b0);
    check_bars("tickwrite");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_bar_scanner.md
Name: fft_bar_scanner

Overview:
Downstream consumer of the FFT processor's VGA read port. After each completed transform it sweeps the N/2 output bins and computes an approximate magnitude for each bin. It converts each magnitude to a bar height with peak-hold and per-frame decay, and holds the heights in a register file that the VGA renderer reads. It also issues the start pulse for the next FFT, so the processor runs continuously.

Parameters:
DATA_WIDTH, 18, width of the signed real/imag bin values
ADDR_WIDTH, 5, FFT address width; bins scanned = 2^(ADDR_WIDTH-1)
BAR_BITS, 8, bar height width
MAG_SHIFT, 10, right shift applied to the magnitude before saturation
DECAY, 1, amount subtracted from every bar on each frame_tick

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
fft_done  in  1  FFT processor done level
fft_start  out  1  one-cycle start pulse to the FFT processor
vga_addr  out  ADDR_WIDTH-1  bin read address to the FFT memory (registered)
vga_data_r  in  DATA_WIDTH  bin real part, valid 1 cycle after vga_addr
vga_data_i  in  DATA_WIDTH  bin imaginary part, same timing
frame_tick  in  1  one-cycle pulse per display frame (decay strobe)
bar_rd_addr  in  ADDR_WIDTH-1  renderer bar index
bar_rd_data  out  BAR_BITS  bar height, combinational from bar_rd_addr
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, fft_start=0, vga_addr=0, all bars=0, pipeline valids=0, busy=0.
- FSM:
  - IDLE: move to KICK on the next cycle.
  - KICK: fft_start=1 for exactly one cycle, then move to WAIT_LOW.
  - WAIT_LOW: wait for fft_done=0. If fft_done stays high for 4 cycles, return to KICK (start was lost).
  - WAIT_HIGH: wait for fft_done=1, then move to SCAN with vga_addr=0.
  - SCAN: vga_addr increments by 1 each cycle. After issuing N/2-1, move to DRAIN.
  - DRAIN: wait until the pipeline valids are empty (4 cycles), then move to KICK.
- Pipeline (valid bit travels with the bin index). Let E0 be the edge at which vga_addr=k is driven.
  - E1: the memory samples the address.
  - E2: register |r| and |i|. Abs saturates: -2^(DATA_WIDTH-1) maps to 2^(DATA_WIDTH-1)-1.
  - E3: mag = max + (min>>2) + (min>>3), unsigned, DATA_WIDTH+1 bits, no overflow possible.
  - E4: h = mag>>MAG_SHIFT, saturated to 2^BAR_BITS-1; the bar update is applied.
  - Bar k is therefore updated at E4, 4 edges after E0.
- Bar update rule, evaluated per bin on every edge:
  - base = (frame_tick ? sat0(bar-DECAY) : bar), floored at 0.
  - If bin k is being written this edge: bar_k = max(h, base). Otherwise bar_k = base.
  - frame_tick coinciding with a write therefore decays first, then applies the peak compare.
- If fft_done falls during SCAN/DRAIN, the scan still completes. Data integrity is the controller's responsibility, because a restart is only issued from KICK.
- bar_rd_data is a pure mux of the bar registers. A read in the same cycle as an update returns the old value.
- Scan period = 4 + (N/2) + FFT compute time. busy stays high continuously after the first kick.

Decomposition:
- Shared package fft_vis_pkg:
  - FSM state enum (IDLE, KICK, WAIT_LOW, WAIT_HIGH, SCAN, DRAIN)
  - alpha-max-beta-min shift constants (2, 3)
  - WAIT_LOW timeout constant (4)
- Sub-module mag_approx: the E2–E3 stages (saturating abs plus max/min combine), 2-cycle latency, parameterised by DATA_WIDTH.

Test Plan:
- Reset release → fft_start pulses once on the 2nd cycle; busy=1. Hold fft_done high → re-KICK after 4 cycles.
- Bin 3 = (3000, -4000), all other bins 0, MAG_SHIFT=10 → mag 5125, bar[3]=5 at E4 after vga_addr=3; all other bars=0.
- Bin 0 = (-131072, 0) → abs 131071, bar[0]=127. Bin 1 = (-131072, -131072) → mag 180221, bar[1]=175.
- MAG_SHIFT=8, bin 1 = (-131072, -131072) → 703 saturates to 255.
- Decay: bar[2]=10, then frame_tick ×3 with no larger input → 7. Next scan with h=4 → stays 4 lower than peak (bar=7). A frame_tick on the same edge as h=9 → 9.
- Assert rst mid-SCAN → same-cycle async clear: bars=0, fft_start=0, vga_addr=0, state IDLE; the sequence restarts with a KICK.
